// File: rtl/bcd_converter.sv
// Sequential double-dabble converter: turns an unsigned magnitude plus sign into
// packed BCD, a minus-sign enable and a significant-digit count for blanking.
module bcd_converter #(
  parameter int WIDTH  = 21,
  parameter int DIGITS = 7
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      answer,
  input  logic                  sign,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  negative,
  output logic [2:0]            num_digits
);

  localparam int                 CNT_W     = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]   LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      shift_q, shift_d;
  logic [4*DIGITS-1:0]   scratch_q, scratch_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  sign_q, sign_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic                  negative_q, negative_d;
  logic [2:0]            num_digits_q, num_digits_d;

  logic [4*DIGITS-1:0]   adjusted;
  logic [4*DIGITS-1:0]   shifted;
  logic [2:0]            sig_digits;

  // Add-3 correction on every digit, then shift the top magnitude bit into the units digit.
  always_comb begin
    adjusted = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adjusted[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
    shifted = {adjusted[4*DIGITS-2:0], shift_q[WIDTH-1]};

    sig_digits = 3'd1;
    for (int i = 0; i < DIGITS; i++) begin
      if (shifted[4*i +: 4] != 4'd0) begin
        sig_digits = 3'(i + 1);
      end
    end
  end

  // NOTE: every _d gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    scratch_d    = scratch_q;
    count_d      = count_q;
    sign_d       = sign_q;
    done_d       = 1'b0;
    bcd_d        = bcd_q;
    negative_d   = negative_q;
    num_digits_d = num_digits_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          shift_d   = answer;
          sign_d    = sign;
          scratch_d = '0;
          count_d   = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        scratch_d = shifted;
        shift_d   = shift_q << 1;
        count_d   = count_q + CNT_W'(1);
        if (count_q == LAST_ITER) begin
          bcd_d        = shifted;
          negative_d   = sign_q && (shifted != '0);
          num_digits_d = sig_digits;
          done_d       = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SHIFT);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      scratch_q    <= '0;
      count_q      <= '0;
      sign_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      bcd_q        <= '0;
      negative_q   <= 1'b0;
      num_digits_q <= 3'd1;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      scratch_q    <= scratch_d;
      count_q      <= count_d;
      sign_q       <= sign_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      bcd_q        <= bcd_d;
      negative_q   <= negative_d;
      num_digits_q <= num_digits_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign bcd        = bcd_q;
  assign negative   = negative_q;
  assign num_digits = num_digits_q;

endmodule

// File: tb/tb_bcd_converter.sv
// Self-checking bench for bcd_converter: directed boundary cases plus random
// magnitudes compared against a decimal-arithmetic reference.
module tb_bcd_converter;

  localparam int WIDTH  = 21;
  localparam int DIGITS = 7;
  localparam int LAT    = WIDTH + 1;

  logic                Clock;
  logic                Reset;
  logic                start;
  logic [WIDTH-1:0]    answer;
  logic                sign;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] bcd;
  logic                negative;
  logic [2:0]          num_digits;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .start      (start),
    .answer     (answer),
    .sign       (sign),
    .busy       (busy),
    .done       (done),
    .bcd        (bcd),
    .negative   (negative),
    .num_digits (num_digits)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: decimal digits by repeated division.
  function automatic logic [31:0] ref_bcd(input int unsigned v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] ref_ndig(input int unsigned v);
    int n;
    n = 1;
    while (v >= 10) begin
      n++;
      v = v / 10;
    end
    return n;
  endfunction

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // One conversion: accept, scramble inputs while in flight, optionally re-poke start.
  task automatic convert(input string tag, input int unsigned val, input logic sgn,
                         input int repoke_at, input int unsigned repoke_val);
    logic [31:0] prev_bcd;
    logic        prev_neg;
    logic [2:0]  prev_nd;
    int n, busy_cnt, unstable;
    bit done_seen;
    prev_bcd = 32'(bcd);
    prev_neg = negative;
    prev_nd  = num_digits;
    start  = 1'b1;
    answer = WIDTH'(val);
    sign   = sgn;
    step();
    busy_cnt  = busy ? 1 : 0;
    unstable  = 0;
    n         = 0;
    done_seen = 0;
    while (n < 2*LAT && !done_seen) begin
      start  = (n == repoke_at);
      answer = start ? WIDTH'(repoke_val) : WIDTH'($urandom);
      sign   = 1'($urandom);
      step();
      n++;
      if (done) done_seen = 1;
      else begin
        if (busy) busy_cnt++;
        if (32'(bcd) !== prev_bcd || negative !== prev_neg || num_digits !== prev_nd)
          unstable++;
      end
    end
    start = 1'b0;
    check({tag, "_latency"}, n + 1, LAT);
    check({tag, "_busy_cycles"}, busy_cnt, WIDTH);
    check({tag, "_stable"}, unstable, 0);
    check({tag, "_bcd"}, 32'(bcd), ref_bcd(val));
    check({tag, "_neg"}, negative, (sgn && val != 0) ? 1 : 0);
    check({tag, "_ndig"}, 32'(num_digits), ref_ndig(val));
    check({tag, "_busy_at_done"}, busy, 0);
    step();
    check({tag, "_done_one_cycle"}, done, 0);
  endtask

  initial begin
    int times[3];
    int t, k, pulses;
    int unsigned v;

    Reset = 1'b1; start = 1'b0; answer = '0; sign = 1'b0;
    step(); step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_bcd", 32'(bcd), 0);
    check("rst_neg", negative, 0);
    check("rst_ndig", 32'(num_digits), 1);

    // Start held during the reset edge must not be accepted.
    start = 1'b1; answer = 21'd5;
    step();
    check("rst_start_ignored", busy, 0);
    Reset = 1'b0; start = 1'b0;
    step();
    check("rst_start_still_idle", busy, 0);

    convert("c1_negzero", 0, 1'b1, -1, 0);
    convert("c2_neg1m", 1048576, 1'b1, -1, 0);
    convert("c3_max", 2097151, 1'b0, -1, 0);
    convert("c3_nine", 9, 1'b0, -1, 0);
    convert("c3_ten", 10, 1'b0, -1, 0);
    convert("b_99", 99, 1'b1, -1, 0);
    convert("b_100", 100, 1'b0, -1, 0);
    convert("b_999999", 999999, 1'b1, -1, 0);
    convert("b_1000000", 1000000, 1'b0, -1, 0);

    // Start while busy is ignored and does not queue.
    convert("c4_ignore", 123, 1'b0, 5, 999);
    pulses = 0;
    for (int i = 0; i < LAT + 5; i++) begin
      step();
      if (done) pulses++;
    end
    check("c4_no_extra_done", pulses, 0);

    // Reset mid-conversion aborts without a done pulse.
    start = 1'b1; answer = 21'd777777; sign = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 9; i++) step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("c5_busy", busy, 0);
    check("c5_done", done, 0);
    check("c5_bcd", 32'(bcd), 0);
    check("c5_neg", negative, 0);
    check("c5_ndig", 32'(num_digits), 1);
    pulses = 0;
    for (int i = 0; i < LAT + 5; i++) begin
      step();
      if (done) pulses++;
    end
    check("c5_no_done", pulses, 0);
    convert("c5_after", 42, 1'b0, -1, 0);

    // Start held high: back-to-back conversions every LAT cycles.
    start = 1'b1; answer = 21'd7; sign = 1'b0;
    t = 0; k = 0;
    while (k < 3 && t < 5*LAT) begin
      step();
      t++;
      if (done) begin
        times[k] = t;
        k++;
        check("c6_bcd", 32'(bcd), ref_bcd(7));
      end
    end
    check("c6_pulses", k, 3);
    check("c6_first", times[0], LAT);
    check("c6_period1", times[1] - times[0], LAT);
    check("c6_period2", times[2] - times[1], LAT);
    start = 1'b0;
    t = 0;
    while (!done && t < 2*LAT) begin
      step();
      t++;
    end
    check("c6_drain", done, 1);
    step();

    for (int i = 0; i < 25; i++) begin
      v = $urandom_range(0, (1 << WIDTH) - 1);
      if (i % 5 == 0) v = $urandom_range(0, 1200);
      convert($sformatf("rnd%0d", i), v, 1'($urandom), -1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
